// File: rtl/aemb_wb_arbiter_pkg.sv
// aemb_wb_arbiter_pkg: shared FSM encoding, master ids and watchdog fill value
// for the iwb/dwb WISHBONE arbiter.
package aemb_wb_arbiter_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, GNT_I = 2'd1, GNT_D = 2'd2} state_e;
   localparam logic M_I = 1'b0;
   localparam logic M_D = 1'b1;
   localparam logic [31:0] TMO_FILL = 32'h0;
endpackage

// File: rtl/aemb_wb_wdog.sv
// aemb_wb_wdog: cycle watchdog for a granted WISHBONE cycle; fires at TMO-1
// unacked cycles and keeps a sticky timeout flag until reset.
module aemb_wb_wdog #(
   parameter int TMO = 255
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic run_i,
   input  logic ack_i,
   output logic fire_o,
   output logic tmo_o
);
   logic [15:0] cnt_q, cnt_d;
   logic        tmo_q, tmo_d;

   // A real ack in the firing cycle wins, so fire is masked by ack.
   always_comb begin
      fire_o = run_i & ~ack_i & (cnt_q == 16'(TMO - 1));
      cnt_d  = !run_i ? 16'd0 : (ack_i || cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
      tmo_d  = tmo_q | fire_o;
   end

   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) begin
         cnt_q <= 16'd0;
         tmo_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         tmo_q <= tmo_d;
      end

   assign tmo_o = tmo_q;
endmodule

// File: rtl/aemb_wb_arbiter.sv
// aemb_wb_arbiter: two-master (iwb/dwb) to one-slave WISHBONE arbiter with locked
// grants and watchdog; define AEMB_ARB_RR_EN for round-robin instead of dwb priority.
module aemb_wb_arbiter
   import aemb_wb_arbiter_pkg::*;
#(
   parameter int AW  = 32,
   parameter int TMO = 255
) (
   input  logic          sys_clk_i,
   input  logic          sys_rst_i,
   input  logic          iwb_stb_i,
   input  logic [AW-1:0] iwb_adr_i,
   output logic [31:0]   iwb_dat_o,
   output logic          iwb_ack_o,
   input  logic          dwb_stb_i,
   input  logic          dwb_we_i,
   input  logic [3:0]    dwb_sel_i,
   input  logic [AW-1:0] dwb_adr_i,
   input  logic [31:0]   dwb_dat_i,
   output logic [31:0]   dwb_dat_o,
   output logic          dwb_ack_o,
   output logic          mwb_stb_o,
   output logic          mwb_we_o,
   output logic [3:0]    mwb_sel_o,
   output logic [AW-1:0] mwb_adr_o,
   output logic [31:0]   mwb_dat_o,
   input  logic [31:0]   mwb_dat_i,
   input  logic          mwb_ack_i,
   output logic          tmo_o
);
   state_e state_q, state_d;
   logic   gnt_i, gnt_d, gstb, fire, pick_d;
`ifdef AEMB_ARB_RR_EN
   logic   last_q, last_d;
`endif

   assign gnt_i = state_q == GNT_I;
   assign gnt_d = state_q == GNT_D;
   assign gstb  = (gnt_i & iwb_stb_i) | (gnt_d & dwb_stb_i);

   aemb_wb_wdog #(.TMO(TMO)) u_wdog (
      .clk_i (sys_clk_i),
      .rst_i (sys_rst_i),
      .run_i (gstb),
      .ack_i (mwb_ack_i),
      .fire_o(fire),
      .tmo_o (tmo_o)
   );

   always_comb begin
`ifdef AEMB_ARB_RR_EN
      pick_d = dwb_stb_i & (~iwb_stb_i | last_q == M_I);
`else
      pick_d = dwb_stb_i;
`endif
      state_d = state_q;
      if (state_q == IDLE)
         state_d = pick_d ? GNT_D : iwb_stb_i ? GNT_I : IDLE;
      else if (!gstb || mwb_ack_i || fire)
         state_d = IDLE;
`ifdef AEMB_ARB_RR_EN
      last_d = (state_q == IDLE && state_d != IDLE) ? ((state_d == GNT_D) ? M_D : M_I) : last_q;
`endif
   end

   always_ff @(posedge sys_clk_i or posedge sys_rst_i)
      if (sys_rst_i) begin
         state_q <= IDLE;
`ifdef AEMB_ARB_RR_EN
         last_q  <= M_I;
`endif
      end else begin
         state_q <= state_d;
`ifdef AEMB_ARB_RR_EN
         last_q  <= last_d;
`endif
      end

   assign mwb_stb_o = gstb;
   assign mwb_adr_o = gnt_d ? dwb_adr_i : gnt_i ? iwb_adr_i : '0;
   assign mwb_we_o  = gnt_d & dwb_we_i;
   assign mwb_sel_o = gnt_d ? dwb_sel_i : gnt_i ? 4'hF : 4'h0;
   assign mwb_dat_o = gnt_d ? dwb_dat_i : 32'h0;

   // A watchdog termination acks the master but returns the fill value.
   assign iwb_ack_o = gnt_i & iwb_stb_i & (mwb_ack_i | fire);
   assign dwb_ack_o = gnt_d & dwb_stb_i & (mwb_ack_i | fire);
   assign iwb_dat_o = (gnt_i & iwb_stb_i & mwb_ack_i) ? mwb_dat_i : TMO_FILL;
   assign dwb_dat_o = (gnt_d & dwb_stb_i & mwb_ack_i) ? mwb_dat_i : TMO_FILL;
endmodule

// File: tb/tb_aemb_wb_arbiter.sv
// tb_aemb_wb_arbiter: scoreboard bench; master request queues feed the DUT, a slave
// model answers with per-request latency, and a monitor checks every ack.
module tb_aemb_wb_arbiter;
   import aemb_wb_arbiter_pkg::*;
   localparam int AW  = 32;
   localparam int TMO = 8;

   typedef struct {logic [AW-1:0] adr; logic we; logic [3:0] sel; logic [31:0] wdat; int lat;} req_t;
   typedef struct {logic [AW-1:0] adr; logic we; logic [3:0] sel; logic [31:0] wdat; logic [31:0] rdat; logic tmo;} exp_t;

   logic          sys_clk_i = 1'b0;
   logic          sys_rst_i = 1'b1;
   logic          iwb_stb_i = 1'b0;
   logic [AW-1:0] iwb_adr_i = '0;
   logic          dwb_stb_i = 1'b0;
   logic          dwb_we_i  = 1'b0;
   logic [3:0]    dwb_sel_i = 4'h0;
   logic [AW-1:0] dwb_adr_i = '0;
   logic [31:0]   dwb_dat_i = 32'h0;
   logic [31:0]   mwb_dat_i = 32'h0;
   logic          mwb_ack_i = 1'b0;
   logic [31:0]   iwb_dat_o, dwb_dat_o, mwb_dat_o;
   logic          iwb_ack_o, dwb_ack_o, mwb_stb_o, mwb_we_o, tmo_o;
   logic [3:0]    mwb_sel_o;
   logic [AW-1:0] mwb_adr_o;

   req_t ipend[$], dpend[$];
   exp_t iexp[$], dexp[$];
   exp_t me;
   int   vecs = 0, errs = 0, scnt = 0;
   logic mon_en = 1'b0, tmo_m = 1'b0, last_m = M_I, exp_d = 1'b0;
   logic prev_stb = 1'b0, prev_i = 1'b0, prev_d = 1'b0, prev_ack = 1'b0;
   logic iack_seen = 1'b0, dack_seen = 1'b0;

   aemb_wb_arbiter #(.AW(AW), .TMO(TMO)) dut (
      .sys_clk_i(sys_clk_i), .sys_rst_i(sys_rst_i),
      .iwb_stb_i(iwb_stb_i), .iwb_adr_i(iwb_adr_i), .iwb_dat_o(iwb_dat_o), .iwb_ack_o(iwb_ack_o),
      .dwb_stb_i(dwb_stb_i), .dwb_we_i(dwb_we_i), .dwb_sel_i(dwb_sel_i), .dwb_adr_i(dwb_adr_i),
      .dwb_dat_i(dwb_dat_i), .dwb_dat_o(dwb_dat_o), .dwb_ack_o(dwb_ack_o),
      .mwb_stb_o(mwb_stb_o), .mwb_we_o(mwb_we_o), .mwb_sel_o(mwb_sel_o), .mwb_adr_o(mwb_adr_o),
      .mwb_dat_o(mwb_dat_o), .mwb_dat_i(mwb_dat_i), .mwb_ack_i(mwb_ack_i), .tmo_o(tmo_o)
   );

   always #5 sys_clk_i = ~sys_clk_i;

   function automatic logic [31:0] mem(input logic [AW-1:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h5A5A_3C3C;
   endfunction

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", n, act, exp);
      end
   endtask

   task automatic push_i(input logic [AW-1:0] a, input int lat);
      ipend.push_back('{adr: a, we: 1'b0, sel: 4'hF, wdat: 32'h0, lat: lat});
      iexp.push_back('{adr: a, we: 1'b0, sel: 4'hF, wdat: 32'h0,
                       rdat: (lat < TMO) ? mem(a) : 32'h0, tmo: lat >= TMO});
   endtask

   task automatic push_d(input logic [AW-1:0] a, input logic we, input logic [3:0] sel,
                         input logic [31:0] wd, input int lat);
      dpend.push_back('{adr: a, we: we, sel: sel, wdat: wd, lat: lat});
      dexp.push_back('{adr: a, we: we, sel: sel, wdat: wd,
                       rdat: (lat < TMO) ? mem(a) : 32'h0, tmo: lat >= TMO});
   endtask

   task automatic drain();
      int n = 0;
      while ((ipend.size() + dpend.size() + iexp.size() + dexp.size()) != 0 && n < 400) begin
         @(negedge sys_clk_i); #2;
         n++;
      end
      if (n >= 400) chk("drain_timeout_pending", 32'(iexp.size() + dexp.size()), 32'd0);
      repeat (2) @(negedge sys_clk_i);
      #2;
   endtask

   // Masters hold stb from their queue head until acked; slave acks after lat stb cycles.
   always begin
      @(posedge sys_clk_i); #1;
      if (iack_seen && ipend.size() > 0) void'(ipend.pop_front());
      if (dack_seen && dpend.size() > 0) void'(dpend.pop_front());
      iwb_stb_i = ipend.size() > 0;
      iwb_adr_i = iwb_stb_i ? ipend[0].adr : '0;
      dwb_stb_i = dpend.size() > 0;
      dwb_adr_i = dwb_stb_i ? dpend[0].adr : '0;
      dwb_we_i  = dwb_stb_i ? dpend[0].we : 1'b0;
      dwb_sel_i = dwb_stb_i ? dpend[0].sel : 4'h0;
      dwb_dat_i = dwb_stb_i ? dpend[0].wdat : 32'h0;
      #1;
      if (!mwb_stb_o) scnt = 0;
      mwb_ack_i = mwb_stb_o && (scnt == (mwb_adr_o[AW-1] ? dpend[0].lat : ipend[0].lat));
      mwb_dat_i = mem(mwb_adr_o);
      #1;
      iack_seen = iwb_ack_o;
      dack_seen = dwb_ack_o;
      if (mwb_stb_o) scnt++;
   end

   always @(negedge sys_clk_i) begin
      if (mon_en) begin
         if (iwb_ack_o) begin
            if (iexp.size() == 0) chk("iwb_unexpected_ack", 32'(iexp.size()), 32'd1);
            else begin
               me = iexp.pop_front();
               chk("iwb_dat", iwb_dat_o, me.rdat);
               chk("iwb_mwb_adr", mwb_adr_o, me.adr);
               chk("iwb_mwb_we_sel", {27'd0, mwb_we_o, mwb_sel_o}, {27'd0, me.we, me.sel});
               chk("iwb_stb_held", 32'(mwb_stb_o), 32'd1);
               chk("iwb_tmo", 32'(tmo_o), 32'(tmo_m));
               chk("iwb_other_quiet", {31'd0, dwb_ack_o} | dwb_dat_o, 32'd0);
               tmo_m = tmo_m | me.tmo;
            end
         end
         if (dwb_ack_o) begin
            if (dexp.size() == 0) chk("dwb_unexpected_ack", 32'(dexp.size()), 32'd1);
            else begin
               me = dexp.pop_front();
               chk("dwb_dat", dwb_dat_o, me.rdat);
               chk("dwb_mwb_adr", mwb_adr_o, me.adr);
               chk("dwb_mwb_we_sel", {27'd0, mwb_we_o, mwb_sel_o}, {27'd0, me.we, me.sel});
               chk("dwb_mwb_wdat", mwb_dat_o, me.wdat);
               chk("dwb_stb_held", 32'(mwb_stb_o), 32'd1);
               chk("dwb_tmo", 32'(tmo_o), 32'(tmo_m));
               chk("dwb_other_quiet", {31'd0, iwb_ack_o} | iwb_dat_o, 32'd0);
               tmo_m = tmo_m | me.tmo;
            end
         end
         if (!mwb_stb_o) chk("idle_no_ack", {30'd0, iwb_ack_o, dwb_ack_o}, 32'd0);
         if (prev_ack) chk("dead_cycle_stb", 32'(mwb_stb_o), 32'd0);
         if (!prev_stb && (prev_i || prev_d)) begin
`ifdef AEMB_ARB_RR_EN
            exp_d = prev_d && (!prev_i || last_m == M_I);
`else
            exp_d = prev_d;
`endif
            chk("grant_rise", 32'(mwb_stb_o), 32'd1);
            chk("grant_master", 32'(mwb_adr_o[AW-1]), 32'(exp_d));
            last_m = mwb_adr_o[AW-1];
         end
      end
      prev_stb = mwb_stb_o;
      prev_i   = iwb_stb_i;
      prev_d   = dwb_stb_i;
      prev_ack = iwb_ack_o | dwb_ack_o;
   end

   initial begin
      logic [31:0] r;
      repeat (2) @(negedge sys_clk_i);
      #2;
      chk("rst_mwb", {mwb_stb_o, mwb_we_o, mwb_sel_o, mwb_adr_o[25:0]}, 32'd0);
      chk("rst_acks_tmo", {29'd0, iwb_ack_o, dwb_ack_o, tmo_o}, 32'd0);
      chk("rst_dat", iwb_dat_o | dwb_dat_o | mwb_dat_o, 32'd0);
      sys_rst_i = 1'b0;
      mon_en = 1'b1;
      @(negedge sys_clk_i); #2;
      push_i(32'h0000_0100, 2);
      drain();
      push_d(32'h8000_0040, 1'b1, 4'h3, 32'hDEAD_BEEF, 1);
      push_i(32'h0000_0200, 0);
      drain();
      push_d(32'h8000_0080, 1'b0, 4'hF, 32'h0, TMO - 1);
      drain();
      chk("tmo_after_coincide", 32'(tmo_o), 32'd0);
      push_d(32'h8000_00C0, 1'b1, 4'hC, 32'h1234_5678, 50);
      drain();
      chk("tmo_sticky_set", 32'(tmo_o), 32'd1);
      push_i(32'h0000_0300, 1);
      drain();
      chk("tmo_sticky_hold", 32'(tmo_o), 32'd1);
      for (int c = 0; c < 600; c++) begin
         @(negedge sys_clk_i); #2;
         r = $urandom();
         if (ipend.size() < 2 && $urandom_range(0, 3) == 0) push_i({1'b0, r[30:2], 2'b00}, $urandom_range(0, 9));
         r = $urandom();
         if (dpend.size() < 2 && $urandom_range(0, 3) == 0)
            push_d({1'b1, r[30:2], 2'b00}, r[0], r[7:4], $urandom(), $urandom_range(0, 9));
      end
      drain();
      mon_en = 1'b0;
      dpend.push_back('{adr: 32'h8000_0800, we: 1'b1, sel: 4'hF, wdat: 32'hCAFE_0001, lat: 100});
      repeat (3) @(negedge sys_clk_i);
      #2;
      chk("pre_reset_grant", {31'd0, mwb_stb_o}, {31'd0, mwb_adr_o[AW-1]});
      sys_rst_i = 1'b1;
      #1;
      chk("rst_async_stb", 32'(mwb_stb_o), 32'd0);
      chk("rst_async_ack_tmo", {29'd0, iwb_ack_o, dwb_ack_o, tmo_o}, 32'd0);
      dpend.delete();
      push_i(32'h0000_0400, 3);
      tmo_m = 1'b0;
      last_m = M_I;
      @(negedge sys_clk_i); #2;
      sys_rst_i = 1'b0;
      mon_en = 1'b1;
      drain();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
